// File: rtl/ft245_tx_arbiter_if.sv
// Request/grant and engine-write bundle between byte sources, the arbiter and the FT245 byte engine.
// The master side is the arbiter; the slave side is the sources plus the engine.
interface ft245_tx_arbiter_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]   REQ;
  logic [N_REQ-1:0]   REQ_LAST;
  logic [8*N_REQ-1:0] REQ_DATA;
  logic [N_REQ-1:0]   ACK;
  logic [N_REQ-1:0]   GNT;
  logic               FT_TXEN;
  logic [7:0]         FT_TX_DATA;
  logic               FT_TX_DONE;
  logic               ERR_CLR;
  logic               TIMEOUT_ERR;

  modport master (
    input  REQ, REQ_LAST, REQ_DATA, FT_TX_DONE, ERR_CLR,
    output ACK, GNT, FT_TXEN, FT_TX_DATA, TIMEOUT_ERR
  );

  modport slave (
    output REQ, REQ_LAST, REQ_DATA, FT_TX_DONE, ERR_CLR,
    input  ACK, GNT, FT_TXEN, FT_TX_DATA, TIMEOUT_ERR
  );
endinterface

// File: rtl/ft245_tx_arbiter.sv
// Round-robin, packet-locked arbiter feeding one FT245 write per accepted byte; ACK/TXEN one cycle after REQ.
// Sources are held off (no ACK) while a byte is in flight; a stalled engine only raises sticky TIMEOUT_ERR.
module ft245_tx_arbiter #(
  parameter int          N_REQ         = 2,
  parameter logic [15:0] TIMEOUT_TICKS = 16'd50000
) (
  input logic                CLK,
  input logic                RST,
  ft245_tx_arbiter_if.master bus
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 2 || N_REQ > 4) begin : g_bad_n_req
    $error("ft245_tx_arbiter: N_REQ must be in 2..4");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q;
  logic [PW-1:0]     owner_q;
  logic              locked_q;
  logic              lastf_q;
  logic [15:0]       wd_q;
  logic              wd_hit_q;
  logic [N_REQ-1:0]  gnt_q;
  logic [N_REQ-1:0]  ack_q;
  logic [7:0]        data_q;
  logic              err_q;

  logic              win_vld;
  logic [PW-1:0]     win_idx;
  logic [N_REQ-1:0]  win_oh;
  logic              take;

  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return s[PW-1:0];
  endfunction

  // Scan from the highest offset down so the lowest offset from PTR is the last writer.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    if (locked_q) begin
      win_idx = owner_q;
      win_vld = bus.REQ[owner_q];
    end else begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (bus.REQ[rr_idx(ptr_q, i)]) begin
          win_vld = 1'b1;
          win_idx = rr_idx(ptr_q, i);
        end
      end
    end
    win_oh          = '0;
    win_oh[win_idx] = 1'b1;
  end

  assign take = (state_q == IDLE) && win_vld;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_vld) state_d = SEND;
      SEND:    if (bus.FT_TX_DONE) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ptr_q    <= '0;
      owner_q  <= '0;
      locked_q <= 1'b0;
      lastf_q  <= 1'b0;
      wd_q     <= '0;
      wd_hit_q <= 1'b0;
      gnt_q    <= '0;
      ack_q    <= '0;
      data_q   <= 8'h00;
    end else begin
      ack_q    <= '0;
      wd_hit_q <= (state_q == SEND) && (wd_q == TIMEOUT_TICKS - 16'd1);
      if (take) begin
        ack_q    <= win_oh;
        gnt_q    <= win_oh;
        owner_q  <= win_idx;
        locked_q <= 1'b1;
        data_q   <= bus.REQ_DATA[int'(win_idx)*8 +: 8];
        lastf_q  <= bus.REQ_LAST[win_idx];
        wd_q     <= '0;
      end
      if (state_q == SEND) begin
        if (wd_q != TIMEOUT_TICKS) wd_q <= wd_q + 16'd1;
        if (bus.FT_TX_DONE && lastf_q) begin
          locked_q <= 1'b0;
          gnt_q    <= '0;
          ptr_q    <= rr_idx(owner_q, 1);
        end
      end
    end
  end

  // wd_hit_q fires once when the watchdog reaches its limit, so a later clear sticks.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)              err_q <= 1'b0;
    else if (wd_hit_q)     err_q <= 1'b1;
    else if (bus.ERR_CLR)  err_q <= 1'b0;
  end

  assign bus.ACK         = ack_q;
  assign bus.GNT         = gnt_q;
  assign bus.FT_TX_DATA  = data_q;
  assign bus.FT_TXEN     = (state_q == SEND) && !bus.FT_TX_DONE;
  assign bus.TIMEOUT_ERR = err_q;

endmodule

// File: tb/tb_ft245_tx_arbiter.sv
// Directed bench for ft245_tx_arbiter: single byte, round-robin, packet lock, spacing, watchdog, reset mid-SEND.
module tb_ft245_tx_arbiter;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  ft245_tx_arbiter_if #(.N_REQ(2)) bus ();

  ft245_tx_arbiter #(.N_REQ(2), .TIMEOUT_TICKS(16'd20)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for an ACK, then checks which requester and the byte presented to the engine.
  task automatic wait_ack(input string tag, input logic [1:0] exp_ack, input logic [7:0] exp_dat);
    int n;
    n = 0;
    while (bus.ACK == 2'b00 && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_ack"}, 32'(bus.ACK), 32'(exp_ack));
    chk({tag, "_dat"}, 32'(bus.FT_TX_DATA), 32'(exp_dat));
    chk({tag, "_txen"}, 32'(bus.FT_TXEN), 32'd1);
  endtask

  task automatic done_pulse();
    bus.FT_TX_DONE = 1'b1;
    step();
    bus.FT_TX_DONE = 1'b0;
  endtask

  task automatic do_reset();
    RST            = 1'b0;
    bus.REQ        = '0;
    bus.FT_TX_DONE = 1'b0;
    bus.ERR_CLR    = 1'b0;
    step();
    step();
    RST = 1'b1;
    step();
  endtask

  logic [7:0] rr_dat [4];
  logic [1:0] rr_ack [4];
  logic       txen_ok;
  int         extra_ack;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rr_dat = '{8'h10, 8'h20, 8'h10, 8'h20};
    rr_ack = '{2'b01, 2'b10, 2'b01, 2'b10};

    RST            = 1'b0;
    bus.REQ        = '0;
    bus.REQ_LAST   = '0;
    bus.REQ_DATA   = '0;
    bus.FT_TX_DONE = 1'b0;
    bus.ERR_CLR    = 1'b0;
    step();
    step();
    chk("rst_gnt",  32'(bus.GNT), 32'd0);
    chk("rst_ack",  32'(bus.ACK), 32'd0);
    chk("rst_txen", 32'(bus.FT_TXEN), 32'd0);
    chk("rst_data", 32'(bus.FT_TX_DATA), 32'h00);
    chk("rst_err",  32'(bus.TIMEOUT_ERR), 32'd0);
    RST = 1'b1;
    step();

    // Single byte, DONE 12 cycles after the ACK cycle
    bus.REQ_DATA[7:0] = 8'hA5;
    bus.REQ_LAST      = 2'b01;
    bus.REQ           = 2'b01;
    wait_ack("single", 2'b01, 8'hA5);
    chk("single_gnt", 32'(bus.GNT), 32'h1);
    bus.REQ   = 2'b00;
    txen_ok   = 1'b1;
    extra_ack = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.FT_TXEN !== 1'b1) txen_ok = 1'b0;
      if (bus.ACK !== 2'b00) extra_ack++;
    end
    chk("single_txen_hold", 32'(txen_ok), 32'd1);
    chk("single_ack_once", 32'(extra_ack), 32'd0);
    bus.FT_TX_DONE = 1'b1;
    #1;
    chk("single_txen_done", 32'(bus.FT_TXEN), 32'd0);
    step();
    bus.FT_TX_DONE = 1'b0;
    chk("single_gnt_clr", 32'(bus.GNT), 32'd0);
    chk("single_txen_idle", 32'(bus.FT_TXEN), 32'd0);

    // Round-robin with both held, every byte a packet end
    do_reset();
    bus.REQ_DATA = {8'h20, 8'h10};
    bus.REQ_LAST = 2'b11;
    bus.REQ      = 2'b11;
    for (int b = 0; b < 4; b++) begin
      wait_ack("rr", rr_ack[b], rr_dat[b]);
      step();
      step();
      if (b == 3) bus.REQ = 2'b00;
      done_pulse();
    end

    // Packet lock: 11,12,13 from requester 0 while requester 1 waits
    do_reset();
    bus.REQ_DATA = {8'h20, 8'h11};
    bus.REQ_LAST = 2'b10;
    bus.REQ      = 2'b11;
    wait_ack("lock_b0", 2'b01, 8'h11);
    chk("lock_gnt0", 32'(bus.GNT), 32'h1);
    step();
    bus.REQ_DATA[7:0] = 8'h12;
    step();
    done_pulse();
    wait_ack("lock_b1", 2'b01, 8'h12);
    chk("lock_gnt1", 32'(bus.GNT), 32'h1);
    step();
    bus.REQ_DATA[7:0] = 8'h13;
    bus.REQ_LAST      = 2'b11;
    step();
    done_pulse();
    wait_ack("lock_b2", 2'b01, 8'h13);
    step();
    bus.REQ[0] = 1'b0;
    step();
    chk("lock_gnt_hold", 32'(bus.GNT), 32'h1);
    done_pulse();
    wait_ack("lock_b3", 2'b10, 8'h20);
    chk("lock_gnt_r1", 32'(bus.GNT), 32'h2);
    bus.REQ = 2'b00;
    step();
    done_pulse();

    // Spacing: DONE one cycle after ACK, next TXEN two cycles after DONE
    do_reset();
    bus.REQ_DATA[7:0] = 8'h33;
    bus.REQ_LAST      = 2'b01;
    bus.REQ           = 2'b01;
    wait_ack("sp0", 2'b01, 8'h33);
    step();
    bus.FT_TX_DONE = 1'b1;
    #1;
    chk("sp_d_txen", 32'(bus.FT_TXEN), 32'd0);
    step();
    bus.FT_TX_DONE = 1'b0;
    chk("sp_d1_txen", 32'(bus.FT_TXEN), 32'd0);
    chk("sp_d1_ack", 32'(bus.ACK), 32'd0);
    step();
    chk("sp_d2_txen", 32'(bus.FT_TXEN), 32'd1);
    chk("sp_d2_ack", 32'(bus.ACK), 32'h1);
    bus.REQ = 2'b00;
    step();
    done_pulse();

    // Watchdog with TIMEOUT_TICKS=20
    do_reset();
    bus.REQ_DATA[7:0] = 8'h44;
    bus.REQ_LAST      = 2'b01;
    bus.REQ           = 2'b01;
    wait_ack("wd0", 2'b01, 8'h44);
    bus.REQ = 2'b00;
    for (int i = 0; i < 20; i++) step();
    chk("wd_pre", 32'(bus.TIMEOUT_ERR), 32'd0);
    step();
    chk("wd_rise", 32'(bus.TIMEOUT_ERR), 32'd1);
    chk("wd_txen", 32'(bus.FT_TXEN), 32'd1);
    step();
    chk("wd_sticky", 32'(bus.TIMEOUT_ERR), 32'd1);
    bus.ERR_CLR = 1'b1;
    step();
    bus.ERR_CLR = 1'b0;
    chk("wd_clr", 32'(bus.TIMEOUT_ERR), 32'd0);
    chk("wd_clr_txen", 32'(bus.FT_TXEN), 32'd1);
    bus.REQ_DATA[7:0] = 8'h55;
    bus.REQ           = 2'b01;
    done_pulse();
    wait_ack("wd1", 2'b01, 8'h55);
    bus.REQ = 2'b00;
    for (int i = 0; i < 20; i++) step();
    chk("wd_pre2", 32'(bus.TIMEOUT_ERR), 32'd0);
    bus.ERR_CLR = 1'b1;
    step();
    bus.ERR_CLR = 1'b0;
    chk("wd_set_wins", 32'(bus.TIMEOUT_ERR), 32'd1);
    done_pulse();

    // Reset mid-SEND while requester 1 holds a packet lock
    do_reset();
    bus.REQ_DATA = {8'h77, 8'h66};
    bus.REQ_LAST = 2'b01;
    bus.REQ      = 2'b01;
    wait_ack("rs0", 2'b01, 8'h66);
    bus.REQ = 2'b10;
    step();
    done_pulse();
    wait_ack("rs1", 2'b10, 8'h77);
    RST = 1'b0;
    #1;
    chk("rs_ack", 32'(bus.ACK), 32'd0);
    chk("rs_gnt", 32'(bus.GNT), 32'd0);
    chk("rs_txen", 32'(bus.FT_TXEN), 32'd0);
    step();
    bus.REQ_LAST = 2'b11;
    bus.REQ      = 2'b11;
    RST          = 1'b1;
    wait_ack("rs_restart", 2'b01, 8'h66);
    bus.REQ = 2'b00;
    step();
    done_pulse();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
